// File: rtl/int_div_unit.sv
// Iterative RV32M divide/remainder unit for integer pipe 2.
// Radix-2 restoring division, one quotient bit per cycle, with
// divide-by-zero and signed-overflow results produced in one cycle.

`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 6
`endif

module int_div_unit #(
    parameter int XLEN           = 32,
    parameter int PRF_INDEX_SIZE = `PRF_INT_INDEX_SIZE,
    parameter int ROB_INDEX_SIZE = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [1:0]                in_op,
    input  logic [XLEN-1:0]           in_rs1,
    input  logic [XLEN-1:0]           in_rs2,
    input  logic [PRF_INDEX_SIZE-1:0] in_rd_prf_index,
    input  logic [ROB_INDEX_SIZE-1:0] in_rob_index,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_result,
    output logic [PRF_INDEX_SIZE-1:0] out_rd_prf_index,
    output logic [ROB_INDEX_SIZE-1:0] out_rob_index,
    output logic                      ctb_valid,
    output logic [PRF_INDEX_SIZE-1:0] ctb_prf_int_index
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t                    state_r, state_n;
    logic [XLEN-1:0]           rem_r, quo_r, dsr_r, result_r;
    logic [5:0]                cnt_r;
    logic                      is_rem_r, neg_q_r, neg_r_r;
    logic [PRF_INDEX_SIZE-1:0] tag_r;
    logic [ROB_INDEX_SIZE-1:0] rob_r;

    logic                      accept_s, is_signed_s, is_rem_s;
    logic                      rs1_neg_s, rs2_neg_s, div0_s, ovf_s;
    logic [XLEN-1:0]           abs1_s, abs2_s, special_s;
    logic [XLEN:0]             shift_s, diff_s;
    logic [XLEN-1:0]           rem_n_s, quo_n_s, q_fix_s, r_fix_s;
    logic                      qbit_s, done_s;

    // Decode the arriving op: operand magnitudes and the one-cycle special results.
    always_comb begin
        accept_s    = in_valid & ~flush;
        is_signed_s = ~in_op[0];
        is_rem_s    = in_op[1];
        rs1_neg_s   = is_signed_s & in_rs1[XLEN-1];
        rs2_neg_s   = is_signed_s & in_rs2[XLEN-1];
        abs1_s      = rs1_neg_s ? ({XLEN{1'b0}} - in_rs1) : in_rs1;
        abs2_s      = rs2_neg_s ? ({XLEN{1'b0}} - in_rs2) : in_rs2;
        div0_s      = (in_rs2 == {XLEN{1'b0}});
        ovf_s       = is_signed_s & (in_rs1 == MIN_INT) & (in_rs2 == {XLEN{1'b1}});
        if (div0_s) begin
            special_s = is_rem_s ? in_rs1 : {XLEN{1'b1}};
        end else begin
            special_s = is_rem_s ? {XLEN{1'b0}} : MIN_INT;
        end
    end

    // One restoring-division step plus the sign fix-up applied on the last step.
    always_comb begin
        shift_s = {rem_r, quo_r[XLEN-1]};
        diff_s  = shift_s - {1'b0, dsr_r};
        if (!diff_s[XLEN]) begin
            rem_n_s = diff_s[XLEN-1:0];
            qbit_s  = 1'b1;
        end else begin
            rem_n_s = shift_s[XLEN-1:0];
            qbit_s  = 1'b0;
        end
        quo_n_s = {quo_r[XLEN-2:0], qbit_s};
        q_fix_s = neg_q_r ? ({XLEN{1'b0}} - quo_n_s) : quo_n_s;
        r_fix_s = neg_r_r ? ({XLEN{1'b0}} - rem_n_s) : rem_n_s;
    end

    // Next-state logic; flush overrides both issue and writeback handshake.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n = (div0_s | ovf_s) ? DONE : BUSY;
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (cnt_r == 6'd1) begin
                    state_n = DONE;
                end else begin
                    state_n = BUSY;
                end
            end
            DONE: begin
                if (flush | out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath: latch the op on accept, iterate in BUSY, capture the fixed-up result.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_r    <= {XLEN{1'b0}};
            quo_r    <= {XLEN{1'b0}};
            dsr_r    <= {XLEN{1'b0}};
            result_r <= {XLEN{1'b0}};
            cnt_r    <= 6'd0;
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            tag_r    <= {PRF_INDEX_SIZE{1'b0}};
            rob_r    <= {ROB_INDEX_SIZE{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        tag_r    <= in_rd_prf_index;
                        rob_r    <= in_rob_index;
                        is_rem_r <= is_rem_s;
                        neg_q_r  <= rs1_neg_s ^ rs2_neg_s;
                        neg_r_r  <= rs1_neg_s;
                        rem_r    <= {XLEN{1'b0}};
                        quo_r    <= abs1_s;
                        dsr_r    <= abs2_s;
                        cnt_r    <= 6'(XLEN);
                        result_r <= special_s;
                    end
                end
                BUSY: begin
                    rem_r <= rem_n_s;
                    quo_r <= quo_n_s;
                    cnt_r <= cnt_r - 6'd1;
                    if (cnt_r == 6'd1) begin
                        result_r <= is_rem_r ? r_fix_s : q_fix_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are forced to zero outside DONE; the valid is killed during a flush.
    always_comb begin
        done_s            = (state_r == DONE);
        busy              = (state_r != IDLE);
        out_valid         = done_s & ~flush;
        out_result        = done_s ? result_r : {XLEN{1'b0}};
        out_rd_prf_index  = done_s ? tag_r : {PRF_INDEX_SIZE{1'b0}};
        out_rob_index     = done_s ? rob_r : {ROB_INDEX_SIZE{1'b0}};
        ctb_valid         = out_valid & out_ready;
        ctb_prf_int_index = out_rd_prf_index;
    end

    int_div_unit_chk u_chk (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .busy     (busy)
    );

endmodule

// Protocol checker: no new divide may be issued while the unit is occupied.
module int_div_unit_chk (
    input logic clock,
    input logic reset,
    input logic flush,
    input logic in_valid,
    input logic busy
);

    a_no_issue_when_busy: assert property (
        @(posedge clock) disable iff (reset) !(in_valid && busy && !flush)
    ) else $error("int_div_unit: in_valid asserted while busy");

endmodule

// File: doc/int_div_unit.md
# int_div_unit

Iterative integer divide execution unit for integer execution pipe 2 (ALU+IntDiv), directly downstream of the integer issue queue and PRF read. It accepts one RV32M divide/remainder operation at a time, computes it with a radix-2 restoring algorithm, and returns the result with its destination PRF tag. While an operation is in flight it holds `ex_busy[2]` high so the issue queue withholds further divides. It also drives the pipe's common-tag-bus entry when the result is written back.

## Interface
- `XLEN`, 32, operand/result width
- `PRF_INDEX_SIZE`, `` `PRF_INT_INDEX_SIZE ``, destination physical register index width
- `ROB_INDEX_SIZE`, 6, ROB tag width carried through unchanged
- `clock`  in  1  clock; all state updates on posedge
- `reset`  in  1  reset, synchronous, active-high
- `flush`  in  1  synchronous kill of the in-flight or arriving op (mispredict/exception)
- `in_valid`  in  1  issue of a divide op this cycle
- `in_op`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `in_rs1`  in  XLEN  dividend
- `in_rs2`  in  XLEN  divisor
- `in_rd_prf_index`  in  PRF_INDEX_SIZE  destination tag
- `in_rob_index`  in  ROB_INDEX_SIZE  ROB tag
- `busy`  out  1  to issue queue `ex_busy[2]`; high when state != IDLE
- `out_valid`  out  1  result available
- `out_ready`  in  1  writeback accepts result
- `out_result`  out  XLEN  quotient or remainder
- `out_rd_prf_index`  out  PRF_INDEX_SIZE  destination tag
- `out_rob_index`  out  ROB_INDEX_SIZE  ROB tag
- `ctb_valid`  out  1  `out_valid & out_ready`
- `ctb_prf_int_index`  out  PRF_INDEX_SIZE  equals `out_rd_prf_index`

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE. All outputs read 0 while in IDLE.
- IDLE:
  - Accept when `in_valid & ~flush`. Latch tags and op.
  - Special case, divisor == 0: go to DONE. Quotient = all ones; remainder = dividend.
  - Special case, signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): go to DONE. Quotient = 0x80000000; remainder = 0.
  - Otherwise: load |rs1| and |rs2| (raw values for DIVU/REMU), clear the partial remainder, set the 6-bit counter to 32, go to BUSY.
- BUSY, one quotient bit per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem (XLEN+1-bit subtract). If non-negative, commit the subtraction and set the quo LSB.
  - Decrement the counter. When it reaches 0, go to DONE.
- Sign fix-up, registered on entry to DONE (signed ops only):
  - Negate the quotient if the operand signs differ.
  - Remainder takes the sign of the dividend.
- DONE: `out_valid`=1 with stable outputs until `out_ready`. On `out_valid & out_ready`, go to IDLE next cycle.
- `flush` in any state: go to IDLE next cycle and drop the result. `out_valid`/`ctb_valid` are 0 in the flush cycle. An arriving `in_valid` in the same cycle is ignored.
- `in_valid` while `busy`=1 is a protocol error: ignored, and a simulation assertion fires.
- `reset` has priority over `flush`; `flush` has priority over `in_valid` and `out_ready`.

## Timing
- Accept at cycle T → `busy`=1 from T+1.
- Normal op: BUSY for T+1..T+32; `out_valid` at T+33. Min latency 33 cycles to result.
- Special case: `out_valid` at T+1.
- Handshake at cycle D → `busy`=0 at D+1. Earliest next accept is D+1, so back-to-back normal divides occur every 34 cycles.
- `ctb_valid` is combinational from `out_ready`, high only in the handshake cycle.
- Reset mid-op: IDLE and outputs 0 on the next edge; no result is ever produced for the aborted op.

## Test plan
- DIVU 100/7 (tag 5) at T → `busy` T+1..T+33, `out_valid` at T+33, result 14; REMU same operands → 2; `ctb_prf_int_index`=5 in the handshake cycle.
- DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); REM 7/−2 → 1.
- DIV 123/0 → 0xFFFFFFFF at T+1; REMU 123/0 → 123; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, both at T+1.
- Hold `out_ready`=0 for 10 cycles in DONE → `out_valid` and result stay stable, `busy` stays 1, `ctb_valid`=0; raise `out_ready` → single `ctb_valid` pulse, `busy`=0 next cycle.
- `flush` at T+10 of a normal op, with a new `in_valid` in the same cycle → IDLE at T+11, new op not accepted, no `out_valid`; an op issued at T+11 completes correctly at T+44.
- `reset` asserted during BUSY, and separately during DONE → all outputs 0 next cycle; the first op after deassertion gives the correct result.
